// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_BUSY = 2'd1,
        MS_FIX  = 2'd2
    } mul_state_t;

    // Widest operand the magnitude helper handles; callers zero-extend into it.
    localparam int MUL_MAX_W = 64;

    // Conditional two's-complement magnitude; the low bits of the result are
    // exact for any narrower zero-extended operand.
    function automatic logic [MUL_MAX_W-1:0] abs_w(input logic [MUL_MAX_W-1:0] val,
                                                   input logic                 neg);
        logic [MUL_MAX_W-1:0] res;
        if (neg) begin
            res = ~val + {{(MUL_MAX_W-1){1'b0}}, 1'b1};
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Final result stage: conditional negate of the unsigned product plus
// overflow detection against a WIDTH-bit result.
module mul_sign_fix import mul_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic               neg,
    input  logic               is_signed,
    output logic [WIDTH-1:0]   lo,
    output logic [WIDTH-1:0]   hi,
    output logic               ovf
);

    logic [2*WIDTH-1:0] prod_s;

    // Negate the magnitude product when operand signs differed, then judge overflow.
    always_comb begin
        if (neg) begin
            prod_s = ~acc + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            prod_s = acc;
        end
        lo = prod_s[WIDTH-1:0];
        hi = prod_s[2*WIDTH-1:WIDTH];
        if (is_signed) begin
            ovf = (hi != {WIDTH{lo[WIDTH-1]}});
        end else begin
            ovf = (hi != {WIDTH{1'b0}});
        end
    end

endmodule

// File: rtl/mul_seq.sv
// Radix-2 shift-add multiplier with start/done handshake, run-time signed
// or unsigned operands, full 2*WIDTH product and overflow flag.
module mul_seq import mul_pkg::*; #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] rs1_reg,
    input  logic [WIDTH-1:0] rs2_reg,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mul_rd,
    output logic [WIDTH-1:0] m_co,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    mul_state_t       state_r, next_state_s;
    logic [WIDTH-1:0] mcand_r, mult_r;
    logic [PW-1:0]    acc_r, acc_step_s, acc_next_s;
    logic [CW-1:0]    count_r, rem_s;
    logic             sign_r, signed_r;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] mag1_s, mag2_s;
    logic             last_s;
    logic [WIDTH-1:0] fix_lo_s, fix_hi_s;
    logic             fix_ovf_s;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which still fits.
    always_comb begin
        mag1_s = WIDTH'(abs_w(MUL_MAX_W'(rs1_reg), is_signed & rs1_reg[WIDTH-1]));
        mag2_s = WIDTH'(abs_w(MUL_MAX_W'(rs2_reg), is_signed & rs2_reg[WIDTH-1]));
    end

    // One shift-add step; mult_r[0] is the multiplier bit under scan.
    always_comb begin
        if (mult_r[0]) begin
            sum_s = {1'b0, acc_r[PW-1:WIDTH]} + {1'b0, mcand_r};
        end else begin
            sum_s = {1'b0, acc_r[PW-1:WIDTH]};
        end
        acc_step_s = {sum_s, acc_r[WIDTH-1:1]};
        rem_s      = CW'(WIDTH - 1) - count_r;
        // Early exit folds the remaining no-add steps into one wide shift.
        if ((EARLY_EXIT == 1'b1) && (mult_r[WIDTH-1:1] == {(WIDTH-1){1'b0}})) begin
            last_s     = 1'b1;
            acc_next_s = acc_step_s >> rem_s;
        end else if (count_r == CW'(WIDTH - 1)) begin
            last_s     = 1'b1;
            acc_next_s = acc_step_s;
        end else begin
            last_s     = 1'b0;
            acc_next_s = acc_step_s;
        end
    end

    mul_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .acc       (acc_r),
        .neg       (sign_r),
        .is_signed (signed_r),
        .lo        (fix_lo_s),
        .hi        (fix_hi_s),
        .ovf       (fix_ovf_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= MS_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            MS_IDLE: begin
                if (start) begin
                    next_state_s = MS_BUSY;
                end else begin
                    next_state_s = MS_IDLE;
                end
            end
            MS_BUSY: begin
                if (last_s) begin
                    next_state_s = MS_FIX;
                end else begin
                    next_state_s = MS_BUSY;
                end
            end
            MS_FIX:  next_state_s = MS_IDLE;
            default: next_state_s = MS_IDLE;
        endcase
    end

    // Datapath and registered handshake/result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_r  <= {WIDTH{1'b0}};
            mult_r   <= {WIDTH{1'b0}};
            acc_r    <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            sign_r   <= 1'b0;
            signed_r <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mul_rd   <= {WIDTH{1'b0}};
            m_co     <= {WIDTH{1'b0}};
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                MS_IDLE: begin
                    if (start) begin
                        mcand_r  <= mag1_s;
                        mult_r   <= mag2_s;
                        sign_r   <= is_signed & (rs1_reg[WIDTH-1] ^ rs2_reg[WIDTH-1]);
                        signed_r <= is_signed;
                        acc_r    <= {PW{1'b0}};
                        count_r  <= {CW{1'b0}};
                        busy     <= 1'b1;
                    end
                end
                MS_BUSY: begin
                    acc_r   <= acc_next_s;
                    mult_r  <= {1'b0, mult_r[WIDTH-1:1]};
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                end
                MS_FIX: begin
                    mul_rd <= fix_lo_s;
                    m_co   <= fix_hi_s;
                    ovf    <= fix_ovf_s;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq: a vector table on both the
// full-latency and early-exit builds, plus handshake and reset sequences.
module tb_mul_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start0, start1, is_signed;
    logic [W-1:0] rs1, rs2;
    logic         busy0, done0, ovf0, busy1, done1, ovf1;
    logic [W-1:0] lo0, hi0, lo1, hi1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mul_seq #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .is_signed(is_signed),
        .rs1_reg(rs1), .rs2_reg(rs2), .busy(busy0), .done(done0),
        .mul_rd(lo0), .m_co(hi0), .ovf(ovf0)
    );

    mul_seq #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .is_signed(is_signed),
        .rs1_reg(rs1), .rs2_reg(rs2), .busy(busy1), .done(done1),
        .mul_rd(lo1), .m_co(hi1), .ovf(ovf1)
    );

    typedef struct {
        logic         ee;
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         ovf;
        int           lat;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done; lat counts edges after accept.
    task automatic run_op(input logic ee, input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b, output logic [W-1:0] lo,
                          output logic [W-1:0] hi, output logic ov, output int lat);
        @(negedge clk);
        is_signed = sgn;
        rs1 = a;
        rs2 = b;
        if (ee) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        lat = 0;
        while (lat < 40 && !(ee ? done1 : done0)) begin
            @(posedge clk);
            #1;
            lat++;
        end
        lo = ee ? lo1 : lo0;
        hi = ee ? hi1 : hi0;
        ov = ee ? ovf1 : ovf0;
    endtask

    initial begin
        logic [W-1:0] lo, hi;
        logic         ov;
        int           lat;
        int           pulses;

        //          ee    sgn   a         b         lo        hi        ovf   lat
        vecs[0]  = '{1'b0, 1'b0, 16'h012C, 16'h00C8, 16'hEA60, 16'h0000, 1'b0, 17};
        vecs[1]  = '{1'b0, 1'b0, 16'h012C, 16'h012C, 16'h5F90, 16'h0001, 1'b1, 17};
        vecs[2]  = '{1'b0, 1'b1, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF, 1'b0, 17};
        vecs[3]  = '{1'b0, 1'b1, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b1, 17};
        vecs[4]  = '{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 17};
        vecs[5]  = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17};
        vecs[6]  = '{1'b0, 1'b1, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 1'b0, 17};
        vecs[7]  = '{1'b0, 1'b1, 16'h8000, 16'h0001, 16'h8000, 16'hFFFF, 1'b0, 17};
        vecs[8]  = '{1'b0, 1'b1, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h3FFF, 1'b1, 17};
        vecs[9]  = '{1'b0, 1'b0, 16'h1234, 16'h0001, 16'h1234, 16'h0000, 1'b0, 17};
        vecs[10] = '{1'b1, 1'b0, 16'h1234, 16'h0001, 16'h1234, 16'h0000, 1'b0, 2};
        vecs[11] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2};
        vecs[12] = '{1'b1, 1'b1, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF, 1'b0, 4};
        vecs[13] = '{1'b1, 1'b1, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b1, 17};
        vecs[14] = '{1'b1, 1'b0, 16'h012C, 16'h0004, 16'h04B0, 16'h0000, 1'b0, 4};
        vecs[15] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 2};

        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        is_signed = 1'b0;
        rs1 = '0;
        rs2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", {31'd0, busy0}, 32'd0);
        check("reset_done", {31'd0, done0}, 32'd0);
        check("reset_lo", {16'd0, lo0}, 32'd0);
        check("reset_hi", {16'd0, hi0}, 32'd0);
        check("reset_ovf", {31'd0, ovf0}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].ee, vecs[i].sgn, vecs[i].a, vecs[i].b, lo, hi, ov, lat);
            check($sformatf("vec%0d_lo", i), {16'd0, lo}, {16'd0, vecs[i].lo});
            check($sformatf("vec%0d_hi", i), {16'd0, hi}, {16'd0, vecs[i].hi});
            check($sformatf("vec%0d_ovf", i), {31'd0, ov}, {31'd0, vecs[i].ovf});
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        end

        // start held through BUSY with new operands: ignored, then accepted in done cycle.
        @(negedge clk);
        is_signed = 1'b0;
        rs1 = 16'h012C;
        rs2 = 16'h00C8;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        rs1 = 16'h0005;
        rs2 = 16'h0007;
        lat = 0;
        while (lat < 40 && !done0) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("hold_lat", lat, 17);
        check("hold_lo", {16'd0, lo0}, 32'h0000EA60);
        @(posedge clk);
        #1;
        check("b2b_busy", {31'd0, busy0}, 32'd1);
        check("b2b_done_low", {31'd0, done0}, 32'd0);
        check("b2b_lo_held", {16'd0, lo0}, 32'h0000EA60);
        start0 = 1'b0;
        lat = 0;
        while (lat < 40 && !done0) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_lat", lat, 17);
        check("b2b_lo", {16'd0, lo0}, 32'h00000023);

        // Reset mid-operation: outputs clear at once, no done pulse afterwards.
        @(negedge clk);
        rs1 = 16'h012C;
        rs2 = 16'h012C;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy0}, 32'd0);
        check("midrst_done", {31'd0, done0}, 32'd0);
        check("midrst_lo", {16'd0, lo0}, 32'd0);
        check("midrst_hi", {16'd0, hi0}, 32'd0);
        check("midrst_ovf", {31'd0, ovf0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (done0) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        run_op(1'b0, 1'b0, 16'h012C, 16'h012C, lo, hi, ov, lat);
        check("post_rst_lo", {16'd0, lo}, 32'h00005F90);
        check("post_rst_hi", {16'd0, hi}, 32'h00000001);
        check("post_rst_ovf", {31'd0, ov}, 32'd1);
        check("post_rst_lat", lat, 17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
